rf_wport_arb: RTL and testbench

RF_WPORT_ARB -- requirements
Module: rf_wport_arb

---
 rtl/rf_wport_arb_pkg.sv | 41 ++++
 rtl/rf_wport_arb_pick.sv | 16 +
 rtl/rf_wport_arb.sv | 119 +++++++++++
 tb/tb_rf_wport_arb.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/rf_wport_arb_pkg.sv
// Shared widths, FSM encoding and slot layout for the register-file write-port arbiter.
package rf_wport_arb_pkg;

    localparam int BUS_64   = 64;
    localparam int BUS_32   = 32;
    localparam int BUS_RIDX = 5;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [BUS_64-1:0]   pc;
        logic [BUS_32-1:0]   inst;
        logic [BUS_RIDX-1:0] rd;
        logic                rd_wen;
        logic [BUS_64-1:0]   wdata;
        logic                src;
    } wb_slot_t;

    // x0 is hardwired zero, so a write enable aimed at it is dropped at capture.
    function automatic wb_slot_t make_slot(
        input logic [BUS_64-1:0]   pc,
        input logic [BUS_32-1:0]   inst,
        input logic [BUS_RIDX-1:0] rd,
        input logic                rd_wen,
        input logic [BUS_64-1:0]   wdata,
        input logic                src
    );
        wb_slot_t s;
        s.pc     = pc;
        s.inst   = inst;
        s.rd     = rd;
        s.rd_wen = rd_wen & (rd != '0);
        s.wdata  = wdata;
        s.src    = src;
        return s;
    endfunction

endpackage

// File: rtl/rf_wport_arb_pick.sv
// Combinational two-way grant: port 0 wins unless port 1 is being forced.
module arb_pick (
    input  logic p0_req_i,
    input  logic p1_req_i,
    input  logic slot_free_i,
    input  logic force_p1_i,
    output logic grant0_o,
    output logic grant1_o
);

    always_comb begin
        grant0_o = slot_free_i & p0_req_i & ~(force_p1_i & p1_req_i);
        grant1_o = slot_free_i & p1_req_i & ~grant0_o;
    end

endmodule

// File: rtl/rf_wport_arb.sv
// Two-port register-file writeback arbiter with a single registered output slot.
// Optional starvation guard for port 1 enabled by defining ARB_STARVE_GUARD_EN.
module rf_wport_arb
    import rf_wport_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_p0_req,
    output logic                o_p0_ack,
    input  logic [BUS_64-1:0]   i_p0_pc,
    input  logic [BUS_32-1:0]   i_p0_inst,
    input  logic [BUS_RIDX-1:0] i_p0_rd,
    input  logic                i_p0_rd_wen,
    input  logic [BUS_64-1:0]   i_p0_rd_wdata,
    input  logic                i_p1_req,
    output logic                o_p1_ack,
    input  logic [BUS_64-1:0]   i_p1_pc,
    input  logic [BUS_32-1:0]   i_p1_inst,
    input  logic [BUS_RIDX-1:0] i_p1_rd,
    input  logic                i_p1_rd_wen,
    input  logic [BUS_64-1:0]   i_p1_rd_wdata,
    output logic                o_out_req,
    input  logic                i_out_ack,
    output logic [BUS_64-1:0]   o_out_pc,
    output logic [BUS_32-1:0]   o_out_inst,
    output logic [BUS_RIDX-1:0] o_out_rd,
    output logic                o_out_rd_wen,
    output logic [BUS_64-1:0]   o_out_rd_wdata,
    output logic                o_out_src
);

    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
        $error("MAX_WAIT must be in 1..15");
    end

    arb_state_e state_q, state_d;
    wb_slot_t   slot_q, slot_d;
    logic       slot_free, grant0, grant1, accept, force_p1;

    // Gating with rst keeps both acks low for the whole reset window.
    assign slot_free = rst & ((state_q == ARB_IDLE) | i_out_ack);
    assign accept    = grant0 | grant1;

    arb_pick u_pick (
        .p0_req_i    (i_p0_req),
        .p1_req_i    (i_p1_req),
        .slot_free_i (slot_free),
        .force_p1_i  (force_p1),
        .grant0_o    (grant0),
        .grant1_o    (grant1)
    );

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);
    logic [3:0] wait_q, wait_d;

    always_comb begin
        wait_d = wait_q;
        if (!i_p1_req || grant1)
            wait_d = '0;
        else if (slot_free && wait_q < WAIT_MAX)
            wait_d = wait_q + 4'd1;
    end

    assign force_p1 = (wait_q == WAIT_MAX);

    always_ff @(posedge clk) begin
        if (!rst) wait_q <= '0;
        else      wait_q <= wait_d;
    end
`else
    assign force_p1 = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: if (accept) state_d = ARB_HOLD;
            ARB_HOLD: if (i_out_ack && !accept) state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // The slot is zeroed on drain so the payload outputs read 0 while idle.
    always_comb begin
        slot_d = slot_q;
        if (grant1)
            slot_d = make_slot(i_p1_pc, i_p1_inst, i_p1_rd, i_p1_rd_wen, i_p1_rd_wdata, 1'b1);
        else if (grant0)
            slot_d = make_slot(i_p0_pc, i_p0_inst, i_p0_rd, i_p0_rd_wen, i_p0_rd_wdata, 1'b0);
        else if (state_q == ARB_HOLD && i_out_ack)
            slot_d = '0;
    end

    always_comb begin
        o_p0_ack       = grant0;
        o_p1_ack       = grant1;
        o_out_req      = (state_q == ARB_HOLD);
        o_out_pc       = slot_q.pc;
        o_out_inst     = slot_q.inst;
        o_out_rd       = slot_q.rd;
        o_out_rd_wen   = slot_q.rd_wen;
        o_out_rd_wdata = slot_q.wdata;
        o_out_src      = slot_q.src;
    end

endmodule

// File: tb/tb_rf_wport_arb.sv
// Self-checking bench for rf_wport_arb: directed vector table, starvation sequence, randomized model run.
module tb_rf_wport_arb;

    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_p0_req, i_p1_req, i_out_ack;
    logic        o_p0_ack, o_p1_ack, o_out_req;
    logic [63:0] i_p0_pc, i_p1_pc, i_p0_rd_wdata, i_p1_rd_wdata, o_out_pc, o_out_rd_wdata;
    logic [31:0] i_p0_inst, i_p1_inst, o_out_inst;
    logic [4:0]  i_p0_rd, i_p1_rd, o_out_rd;
    logic        i_p0_rd_wen, i_p1_rd_wen, o_out_rd_wen, o_out_src;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_wport_arb #(.MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .i_p0_req(i_p0_req), .o_p0_ack(o_p0_ack),
        .i_p0_pc(i_p0_pc), .i_p0_inst(i_p0_inst), .i_p0_rd(i_p0_rd),
        .i_p0_rd_wen(i_p0_rd_wen), .i_p0_rd_wdata(i_p0_rd_wdata),
        .i_p1_req(i_p1_req), .o_p1_ack(o_p1_ack),
        .i_p1_pc(i_p1_pc), .i_p1_inst(i_p1_inst), .i_p1_rd(i_p1_rd),
        .i_p1_rd_wen(i_p1_rd_wen), .i_p1_rd_wdata(i_p1_rd_wdata),
        .o_out_req(o_out_req), .i_out_ack(i_out_ack),
        .o_out_pc(o_out_pc), .o_out_inst(o_out_inst), .o_out_rd(o_out_rd),
        .o_out_rd_wen(o_out_rd_wen), .o_out_rd_wdata(o_out_rd_wdata),
        .o_out_src(o_out_src)
    );

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        rst, r0;
        logic [4:0]  rd0;
        logic [63:0] wd0;
        logic        r1;
        logic [4:0]  rd1;
        logic [63:0] wd1;
        logic        oack;
        logic        e_a0, e_a1, e_req;
        logic [4:0]  e_rd;
        logic [63:0] e_wd;
        logic        e_wen, e_src;
    } vec_t;

    function automatic vec_t mkv(
        input logic rst_v, input logic r0, input logic [4:0] rd0, input logic [63:0] wd0,
        input logic r1, input logic [4:0] rd1, input logic [63:0] wd1, input logic oack,
        input logic a0, input logic a1, input logic req, input logic [4:0] rd,
        input logic [63:0] wd, input logic wen, input logic src);
        vec_t v;
        v.rst = rst_v; v.r0 = r0; v.rd0 = rd0; v.wd0 = wd0;
        v.r1 = r1; v.rd1 = rd1; v.wd1 = wd1; v.oack = oack;
        v.e_a0 = a0; v.e_a1 = a1; v.e_req = req; v.e_rd = rd;
        v.e_wd = wd; v.e_wen = wen; v.e_src = src;
        return v;
    endfunction

    // Reference model: one pending write slot plus the port-1 wait count.
    typedef struct {
        logic        req;
        logic [63:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic        wen;
        logic [63:0] wd;
    } rq_t;

    logic   m_pend;
    rq_t    m_pay;
    logic   m_src;
    int     m_cnt;
    rq_t    q0, q1;

    initial begin
        vec_t tv[16];
        logic e0, e1, free, force1;
        int   ncyc;

        tv[0]  = mkv(0, 1, 5, 64'h1234, 1, 7, 64'h77, 0,  0, 0, 0, 0, 0, 0, 0);
        tv[1]  = mkv(1, 1, 5, 64'h1234, 0, 0, 0, 0,       1, 0, 1, 5, 64'h1234, 1, 0);
        tv[2]  = mkv(1, 1, 6, 64'hAAAA, 0, 0, 0, 0,       0, 0, 1, 5, 64'h1234, 1, 0);
        tv[3]  = mkv(1, 1, 6, 64'hAAAA, 0, 0, 0, 0,       0, 0, 1, 5, 64'h1234, 1, 0);
        tv[4]  = mkv(1, 1, 6, 64'hAAAA, 0, 0, 0, 0,       0, 0, 1, 5, 64'h1234, 1, 0);
        tv[5]  = mkv(1, 1, 6, 64'hAAAA, 0, 0, 0, 1,       1, 0, 1, 6, 64'hAAAA, 1, 0);
        tv[6]  = mkv(1, 0, 0, 0, 1, 9, 64'h99, 0,         0, 0, 1, 6, 64'hAAAA, 1, 0);
        tv[7]  = mkv(1, 0, 0, 0, 1, 9, 64'h99, 1,         0, 1, 1, 9, 64'h99, 1, 1);
        tv[8]  = mkv(1, 1, 0, 64'hFFFF, 0, 0, 0, 1,       1, 0, 1, 0, 64'hFFFF, 0, 0);
        tv[9]  = mkv(1, 0, 0, 0, 0, 0, 0, 1,              0, 0, 0, 0, 0, 0, 0);
        tv[10] = mkv(1, 0, 0, 0, 0, 0, 0, 1,              0, 0, 0, 0, 0, 0, 0);
        tv[11] = mkv(1, 1, 3, 64'h33, 1, 4, 64'h44, 0,    1, 0, 1, 3, 64'h33, 1, 0);
        tv[12] = mkv(1, 0, 0, 0, 1, 4, 64'h44, 1,         0, 1, 1, 4, 64'h44, 1, 1);
        tv[13] = mkv(0, 1, 8, 64'h88, 0, 0, 0, 0,         0, 0, 0, 0, 0, 0, 0);
        tv[14] = mkv(1, 1, 8, 64'h88, 0, 0, 0, 0,         1, 0, 1, 8, 64'h88, 1, 0);
        tv[15] = mkv(1, 0, 0, 0, 0, 0, 0, 1,              0, 0, 0, 0, 0, 0, 0);

        i_p0_pc = 64'hC000; i_p0_inst = 32'h13; i_p0_rd_wen = 1'b1;
        i_p1_pc = 64'hD000; i_p1_inst = 32'h33; i_p1_rd_wen = 1'b1;

        for (int i = 0; i < 16; i++) begin
            rst = tv[i].rst; i_out_ack = tv[i].oack;
            i_p0_req = tv[i].r0; i_p0_rd = tv[i].rd0; i_p0_rd_wdata = tv[i].wd0;
            i_p1_req = tv[i].r1; i_p1_rd = tv[i].rd1; i_p1_rd_wdata = tv[i].wd1;
            #1;
            chk($sformatf("vec%0d_acks", i), 192'({o_p0_ack, o_p1_ack}),
                192'({tv[i].e_a0, tv[i].e_a1}));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_out", i),
                192'({o_out_req, o_out_rd, o_out_rd_wen, o_out_rd_wdata, o_out_src}),
                192'({tv[i].e_req, tv[i].e_rd, tv[i].e_wen, tv[i].e_wd, tv[i].e_src}));
        end

        // Both ports requesting continuously with the consumer always ready.
        rst = 1; i_out_ack = 1;
        i_p0_req = 1; i_p0_rd = 1; i_p0_rd_wdata = 64'h1;
        i_p1_req = 1; i_p1_rd = 2; i_p1_rd_wdata = 64'h2;
        for (int c = 1; c <= 10; c++) begin
            #1;
`ifdef ARB_STARVE_GUARD_EN
            e1 = (c % (MW + 1) == 0);
`else
            e1 = 1'b0;
`endif
            chk($sformatf("starve_c%0d", c), 192'({o_p0_ack, o_p1_ack}), 192'({~e1, e1}));
            @(posedge clk); #1;
        end
        i_p0_req = 0; i_p1_req = 0;
        @(posedge clk); #1;
        chk("drain_idle", 192'(o_out_req), 192'(0));

        // Randomized run against the reference model.
        m_pend = 0; m_pay = '{default: '0}; m_src = 0; m_cnt = 0;
        q0 = '{default: '0}; q1 = '{default: '0};
        ncyc = 3000;
        for (int c = 0; c < ncyc; c++) begin
            if (!q0.req && ($urandom % 3 == 0)) begin
                q0.req = 1; q0.pc = {$urandom, $urandom}; q0.inst = $urandom;
                q0.rd = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom); q0.wen = 1'($urandom);
                q0.wd = {$urandom, $urandom};
            end
            if (!q1.req && ($urandom % 3 == 0)) begin
                q1.req = 1; q1.pc = {$urandom, $urandom}; q1.inst = $urandom;
                q1.rd = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom); q1.wen = 1'($urandom);
                q1.wd = {$urandom, $urandom};
            end
            rst = ($urandom % 40 != 0);
            i_out_ack = ($urandom % 3 != 0);
            i_p0_req = q0.req; i_p0_pc = q0.pc; i_p0_inst = q0.inst;
            i_p0_rd = q0.rd; i_p0_rd_wen = q0.wen; i_p0_rd_wdata = q0.wd;
            i_p1_req = q1.req; i_p1_pc = q1.pc; i_p1_inst = q1.inst;
            i_p1_rd = q1.rd; i_p1_rd_wen = q1.wen; i_p1_rd_wdata = q1.wd;

            free = rst && (!m_pend || i_out_ack);
`ifdef ARB_STARVE_GUARD_EN
            force1 = (m_cnt == MW);
`else
            force1 = 1'b0;
`endif
            e0 = free && q0.req && !(force1 && q1.req);
            e1 = free && q1.req && !e0;
            #1;
            chk($sformatf("rnd%0d_acks", c), 192'({o_p0_ack, o_p1_ack}), 192'({e0, e1}));
            @(posedge clk);

            if (!rst) begin
                m_pend = 0; m_pay = '{default: '0}; m_src = 0; m_cnt = 0;
            end else begin
                if (e0 || e1) begin
                    m_pend = 1; m_src = e1;
                    m_pay = e1 ? q1 : q0;
                    m_pay.wen = m_pay.wen && (m_pay.rd != 0);
                end else if (m_pend && i_out_ack) begin
                    m_pend = 0; m_pay = '{default: '0}; m_src = 0;
                end
                if (!q1.req || e1) m_cnt = 0;
                else if (free && m_cnt < MW) m_cnt++;
            end
            if (e0) q0.req = 0;
            if (e1) q1.req = 0;

            #1;
            chk($sformatf("rnd%0d_out", c),
                192'({o_out_req, o_out_pc, o_out_inst, o_out_rd, o_out_rd_wen, o_out_rd_wdata, o_out_src}),
                192'({m_pend, m_pay.pc, m_pay.inst, m_pay.rd, m_pay.wen, m_pay.wd, m_src}));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
